// File: rtl/note_sequencer.sv
// Note playback controller: fetches note words from a synchronous-read memory, drives four
// tone voices' pitch/enable, and holds each note for dur x TICK_DIV clock cycles.
module note_sequencer #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned TICK_DIV = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_data,
    output logic [63:0]       voice_period,
    output logic [3:0]        voice_en,
    output logic              note_strobe,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {StIdle, StFetch, StExec, StPlay, StDone} state_e;

    localparam int unsigned    PreW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [63:0]         period_q, period_d;
    logic [3:0]          en_q, en_d;
    logic                strobe_q, strobe_d;
    logic [7:0]          dur_q, dur_d;
    logic [7:0]          tick_q, tick_d;
    logic [PreW-1:0]     pre_q, pre_d;

    logic [7:0]  cmd;
    logic [7:0]  dur;
    logic [15:0] pitch;
    logic        is_note, is_rest, is_end;

    assign cmd     = mem_data[31:24];
    assign dur     = mem_data[23:16];
    assign pitch   = mem_data[15:0];
    assign is_note = (cmd[7:4] == 4'h0);
    assign is_rest = (cmd == 8'h20);
    assign is_end  = (cmd == 8'h11);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        period_d   = period_q;
        en_d       = en_q;
        strobe_d   = 1'b0;
        dur_d      = dur_q;
        tick_d     = tick_q;
        pre_d      = pre_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StFetch;
                    addr_d     = '0;
                    mem_addr_d = '0;
                end
            end
            StFetch: state_d = StExec;
            StExec: begin
                addr_d = addr_q + 1'b1;
                if (is_end) begin
                    en_d    = 4'b0000;
                    state_d = StDone;
                end else if (is_note || is_rest) begin
                    strobe_d = 1'b1;
                    if (is_note) begin
                        for (int v = 0; v < 4; v++) begin
                            if (cmd[v]) begin
                                period_d[16*v +: 16] = pitch;
                                en_d[v]              = 1'b1;
                            end
                        end
                    end else begin
                        en_d = 4'b0000;
                    end
                    dur_d  = dur;
                    tick_d = '0;
                    pre_d  = '0;
                    if (dur != 8'd0) begin
                        state_d = StPlay;
                    end else begin
                        state_d    = StFetch;
                        mem_addr_d = addr_q + 1'b1;
                    end
                end else begin
                    state_d    = StFetch;
                    mem_addr_d = addr_q + 1'b1;
                end
            end
            StPlay: begin
                if (pre_q == PreLast) begin
                    pre_d = '0;
                    if (tick_q == dur_q - 8'd1) begin
                        state_d    = StFetch;
                        mem_addr_d = addr_q;
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // stop overrides everything, including a simultaneous start
        if (stop && state_q != StIdle) begin
            state_d    = StIdle;
            en_d       = 4'b0000;
            addr_d     = '0;
            mem_addr_d = '0;
            strobe_d   = 1'b0;
        end else if (stop) begin
            state_d    = StIdle;
            addr_d     = addr_q;
            mem_addr_d = mem_addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            mem_addr_q <= '0;
            period_q   <= '0;
            en_q       <= '0;
            strobe_q   <= 1'b0;
            dur_q      <= '0;
            tick_q     <= '0;
            pre_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            period_q   <= period_d;
            en_q       <= en_d;
            strobe_q   <= strobe_d;
            dur_q      <= dur_d;
            tick_q     <= tick_d;
            pre_q      <= pre_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_rd       = (state_q == StFetch);
    assign voice_period = period_q;
    assign voice_en     = en_q;
    assign note_strobe  = strobe_q;
    assign busy         = (state_q == StFetch) || (state_q == StExec) || (state_q == StPlay);
    assign done         = (state_q == StDone);

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Playback controller for the sound card's music store: fetches 32-bit note words from a synchronous-read note memory, decodes them into per-voice pitch and enable settings for four tone voices, and holds each note for a programmed number of ticks. It stops at the end marker 32'h11000000, so playback termination is a hardware state rather than a testbench watch. It sits between the note memory and the voice generators/mixer that produce the 8-bit combined output.

## Interface
- ADDR_W, 8: note memory address width.
- TICK_DIV, 1024: clk cycles per duration tick; must be ≥1.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins playback at address 0 from IDLE or DONE.
- stop  in  1  one-cycle pulse; aborts playback to IDLE.
- mem_addr  out  ADDR_W  note memory read address.
- mem_rd  out  1  read strobe; data valid on mem_data the following cycle.
- mem_data  in  32  note word.
- voice_period  out  64  four 16-bit half-period values, voice v at [16v+15:16v].
- voice_en  out  4  per-voice enable; a disabled voice is silent.
- note_strobe  out  1  one-cycle pulse when a note/rest word is applied.
- busy  out  1  high in FETCH, EXEC, PLAY.
- done  out  1  high in DONE.

## Operation
- Note word: [31:24] cmd, [23:16] dur (ticks), [15:0] pitch.
- cmd 8'h00–8'h0F: note; cmd[3:0] is a voice mask. Masked voices get voice_period=pitch and voice_en=1; unmasked voices are unchanged.
- cmd 8'h20: rest; voice_en←0, periods unchanged.
- cmd 8'h11: end marker, whole word don't-care below cmd; go to DONE with voice_en←0.
- Any other cmd: no-op, no strobe, fetch the next word immediately.
- States: IDLE, FETCH, EXEC, PLAY, DONE.
- IDLE: start→FETCH with addr=0.
- FETCH (1 cycle): mem_rd=1, mem_addr=addr. Always goes to EXEC.
- EXEC (1 cycle): decodes mem_data. Outputs update on the edge leaving EXEC, and addr←addr+1 on that same edge.
  - End marker → DONE.
  - Note/rest with dur>0 → PLAY.
  - Note/rest with dur=0 → FETCH, for chord building with no hold time.
  - No-op → FETCH.
- PLAY: lasts exactly dur×TICK_DIV cycles, then FETCH. The prescaler and tick counter clear on PLAY entry.
- DONE: outputs held muted. start→FETCH with addr=0, which replays from the top.
- addr wraps from 2^ADDR_W−1 to 0 and playback continues.
- stop in any state except IDLE → IDLE next edge: voice_en←0, addr←0, no memory read. stop and start in the same cycle: stop wins.
- start while busy is ignored.

## Timing
- Reset (async, rst_n=0): state IDLE; mem_addr=0, mem_rd=0, voice_period=0, voice_en=0, note_strobe=0, busy=0, done=0. Playback in progress is abandoned immediately.
- start sampled at edge E0 → FETCH during cycle 1, EXEC during cycle 2. voice_en/voice_period/note_strobe are valid in cycle 3.
- Word-to-word spacing:
  - dur=0 or no-op: 2 cycles.
  - dur=d: 2 + d×TICK_DIV cycles.
- note_strobe is high for exactly the first cycle the new settings are visible.
- mem_rd is high only in FETCH; mem_addr holds its value outside FETCH.
- done rises in the first cycle after EXEC decodes the end marker.

## Test plan
- Reset: rst_n=0 mid-PLAY → all outputs 0 asynchronously, state IDLE. Release, then start → first mem_rd at addr 0.
- Basic note, TICK_DIV=4: mem[0]=32'h01_03_0100, mem[1]=32'h11000000; start at E0.
  - voice_en=4'b0001 and voice_period[15:0]=16'h0100 from cycle 3, for 12 cycles.
  - Then FETCH addr 1; done high from cycle 17.
- Chord: mem[0]=32'h01_00_0100, mem[1]=32'h06_02_0200, mem[2]=end.
  - voice_en=4'b0111; periods v0=16'h0100, v1=v2=16'h0200.
  - Two note_strobe pulses 2 cycles apart.
- Rest and no-op: mem[0]=32'h03_01_0080, mem[1]=32'h55_00_0000, mem[2]=32'h20_02_0000, mem[3]=end.
  - No strobe for the no-op; voice_en=0 for 8 cycles during the rest; periods retain 16'h0080.
- Stop and restart: stop during PLAY → IDLE next edge, voice_en=0, busy=0. stop+start in the same cycle from DONE → stays IDLE.
- Wrap, ADDR_W=2: no end marker, all words dur=0 → addr sequence 0,1,2,3,0 with busy continuously high.
